// File: rtl/adder_stream_arbiter_if.sv
// Bundle of requester streams, adder stream, adder response and requester responses
// shared by adder_stream_arbiter and its environment.
`timescale 1ns/1ps
interface adder_stream_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATAW      = 64,
  parameter int AXIS_DATAW = 512
);
  // Every channel is valid/ready: a beat or response moves on a rising clk edge where both
  // valid and ready are 1; once raised, valid and its payload hold until that edge.
  logic [NUM_REQ-1:0]            s_tvalid;
  logic [NUM_REQ-1:0]            s_tlast;
  logic [NUM_REQ*AXIS_DATAW-1:0] s_tdata;
  logic [NUM_REQ-1:0]            s_tready;

  logic                          m_tvalid;
  logic                          m_tlast;
  logic [AXIS_DATAW-1:0]         m_tdata;
  logic                          m_tready;

  logic                          adder_clr;
  logic [DATAW-1:0]              adder_rsp;
  logic                          adder_rsp_valid;

  logic [DATAW-1:0]              rsp_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic                          rsp_err;

  // The arbiter drives the adder stream and the responses.
  modport master (
    input  s_tvalid, s_tlast, s_tdata, m_tready, adder_rsp, adder_rsp_valid, rsp_ready,
    output s_tready, m_tvalid, m_tlast, m_tdata, adder_clr, rsp_data, rsp_valid, rsp_err
  );

  modport slave (
    output s_tvalid, s_tlast, s_tdata, m_tready, adder_rsp, adder_rsp_valid, rsp_ready,
    input  s_tready, m_tvalid, m_tlast, m_tdata, adder_clr, rsp_data, rsp_valid, rsp_err
  );
endinterface

// File: rtl/adder_stream_arbiter.sv
// Packet-granular round-robin sharing of one stream adder among NUM_REQ requesters.
// Optional WAIT_RSP watchdog enabled by defining ADDER_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module adder_stream_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATAW      = 64,
  parameter int AXIS_DATAW = 512,
  parameter int REQW       = $clog2(NUM_REQ),
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_stream_arbiter_if.master bus,
  output logic [REQW-1:0]       grant_id,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  if (NUM_REQ < 2 || TIMEOUT < 2 || TIMEOUT > 65536) begin : g_param_check
    $error("adder_stream_arbiter: NUM_REQ must be >= 2 and TIMEOUT in [2, 65536]");
  end

  logic [2:0]            state;
  logic [REQW-1:0]       rr_ptr;
  logic [DATAW-1:0]      rsp_data_q;
  logic                  pick_found;
  logic [REQW-1:0]       pick_idx;
  logic [REQW:0]         cand_sum;
  logic [REQW-1:0]       cand_idx;
  logic                  beat_xfer;
  logic                  wait_timeout;
  logic [AXIS_DATAW-1:0] s_data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign s_data_arr[i] = bus.s_tdata[i*AXIS_DATAW +: AXIS_DATAW];
  end

  // Walk from the farthest candidate back to rr_ptr so the nearest valid requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr} + (REQW+1)'(k);
      cand_idx = (cand_sum >= (REQW+1)'(NUM_REQ)) ? REQW'(cand_sum - (REQW+1)'(NUM_REQ))
                                                   : REQW'(cand_sum);
      if (bus.s_tvalid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    bus.s_tready  = '0;
    bus.m_tvalid  = 1'b0;
    bus.m_tlast   = 1'b0;
    bus.m_tdata   = '0;
    bus.rsp_valid = '0;
    if (state == ST_STREAM) begin
      bus.m_tvalid           = bus.s_tvalid[grant_id];
      bus.m_tlast            = bus.s_tlast[grant_id];
      bus.m_tdata            = s_data_arr[grant_id];
      bus.s_tready[grant_id] = bus.m_tready;
    end
    if (state == ST_RESP) begin
      bus.rsp_valid[grant_id] = 1'b1;
    end
  end

  assign beat_xfer     = bus.m_tvalid && bus.m_tready;
  assign bus.adder_clr = (state == ST_CLEAR);
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

`ifdef ADDER_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        rsp_err_q;

  // Held at zero throughout STREAM so the count starts at 0 on the first WAIT_RSP cycle.
  assign wait_timeout = (state == ST_WAIT) && !bus.adder_rsp_valid &&
                        (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == ST_STREAM) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (state == ST_WAIT && bus.adder_rsp_valid) begin
        rsp_err_q <= 1'b0;
      end else if (wait_timeout) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign wait_timeout = 1'b0;
  assign bus.rsp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: state <= ST_STREAM;
        ST_STREAM: begin
          if (beat_xfer && bus.m_tlast) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.adder_rsp_valid) begin
            rsp_data_q <= bus.adder_rsp;
            state      <= ST_RESP;
          end else if (wait_timeout) begin
            rsp_data_q <= '0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready[grant_id]) begin
            rr_ptr <= (grant_id == REQW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Structural invariants of the arbiter outputs.
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.rsp_valid));
  a_tready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.s_tready));
  a_clr_single: assert property (@(posedge clk) disable iff (!rst) bus.adder_clr |=> !bus.adder_clr);

endmodule

// File: tb/tb_adder_stream_arbiter.sv
// Directed bench for adder_stream_arbiter with a behavioural stream adder on the m_* side.
`timescale 1ns/1ps
module tb_adder_stream_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATAW      = 64;
  localparam int AXIS_DATAW = 512;
  localparam int REQW       = 2;
`ifdef ADDER_ARB_TIMEOUT_EN
  localparam int TIMEOUT    = 8;
`else
  localparam int TIMEOUT    = 1024;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adder_stream_arbiter_if #(.NUM_REQ(NUM_REQ), .DATAW(DATAW), .AXIS_DATAW(AXIS_DATAW)) bus ();

  logic [REQW-1:0] grant_id;
  logic            busy;
  logic [2:0]      state_dbg;

  adder_stream_arbiter #(
    .NUM_REQ(NUM_REQ), .DATAW(DATAW), .AXIS_DATAW(AXIS_DATAW), .REQW(REQW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .busy(busy), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // behavioural adder
  logic [DATAW-1:0] acc = '0;
  logic             fin = 1'b0;
  logic             adder_mute = 1'b0;
  int               clr_cnt = 0;

  always @(posedge clk) begin
    if (bus.adder_clr) begin
      acc     <= '0;
      fin     <= 1'b0;
      clr_cnt <= clr_cnt + 1;
    end else if (bus.m_tvalid && bus.m_tready) begin
      acc <= acc + bus.m_tdata[DATAW-1:0];
      if (bus.m_tlast) fin <= 1'b1;
    end
  end
  assign bus.adder_rsp       = acc;
  assign bus.adder_rsp_valid = fin && !adder_mute;

  logic [AXIS_DATAW-1:0] pk [NUM_REQ][8];

  // driver tasks
  task automatic drive_beat(input int r, input int i, input int n);
    bus.s_tvalid[r] = 1'b1;
    bus.s_tlast[r]  = (i == n - 1);
    bus.s_tdata[r*AXIS_DATAW +: AXIS_DATAW] = pk[r][i];
  endtask

  task automatic release_req(input int r);
    bus.s_tvalid[r] = 1'b0;
    bus.s_tlast[r]  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.s_tvalid = '0;
    bus.s_tlast = '0;
    bus.rsp_ready = '0;
    bus.m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Sends beats of requester r until stop_after beats moved; first_hs = cycles to first beat.
  task automatic send_packet(input int r, input int n, input int stop_after, input bit toggle,
                             output int first_hs);
    int i;
    int guard;
    bit hs;
    logic [NUM_REQ-1:0] oh;
    i = 0;
    guard = 0;
    first_hs = -1;
    oh = '0;
    oh[r] = 1'b1;
    drive_beat(r, 0, n);
    while (i < stop_after && guard < 200) begin
      if (toggle) bus.m_tready = (guard % 2 == 0);
      #1;
      hs = bus.s_tready[r] && bus.m_tvalid;
      checks++;
      if ((bus.s_tready & ~oh) !== '0) begin
        errors++;
        $display("FAIL tready_other req=%0d s_tready=%b required only bit %0d", r, bus.s_tready, r);
      end
      if (hs && first_hs < 0) first_hs = guard;
      @(posedge clk); #1;
      guard++;
      if (hs) begin
        i++;
        if (i < n) drive_beat(r, i, n);
        else release_req(r);
      end
    end
    bus.m_tready = 1'b1;
    checks++;
    if (i != stop_after) begin
      errors++;
      $display("FAIL pkt_beats req=%0d moved=%0d required=%0d", r, i, stop_after);
    end
  endtask

  task automatic get_rsp(input int r, input logic [DATAW-1:0] exp_data, input logic exp_err,
                         input int hold);
    int guard;
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    guard = 0;
    while (bus.rsp_valid !== oh && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (bus.rsp_valid !== oh) begin
      errors++;
      $display("FAIL rsp_valid req=%0d got=%b required=%b", r, bus.rsp_valid, oh);
    end
    checks++;
    if (bus.rsp_data !== exp_data) begin
      errors++;
      $display("FAIL rsp_data req=%0d got=%0d required=%0d", r, bus.rsp_data, exp_data);
    end
    checks++;
    if (bus.rsp_err !== exp_err) begin
      errors++;
      $display("FAIL rsp_err req=%0d got=%b required=%b", r, bus.rsp_err, exp_err);
    end
    checks++;
    if (grant_id !== REQW'(r)) begin
      errors++;
      $display("FAIL rsp_grant got=%0d required=%0d", grant_id, r);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== oh || bus.rsp_data !== exp_data) begin
        errors++;
        $display("FAIL rsp_hold cycle=%0d valid=%b data=%0d required valid=%b data=%0d",
                 h, bus.rsp_valid, bus.rsp_data, oh, exp_data);
      end
    end
    bus.rsp_ready = oh;
    @(posedge clk); #1;
    bus.rsp_ready = '0;
    checks++;
    if (bus.rsp_valid !== '0) begin
      errors++;
      $display("FAIL rsp_drop got=%b required=0", bus.rsp_valid);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (busy !== 1'b0 || state_dbg !== 3'd0 || grant_id !== '0) begin
      errors++;
      $display("FAIL %s_state busy=%b state=%0d grant=%0d required 0,0,0", tag, busy, state_dbg, grant_id);
    end
    checks++;
    if (bus.s_tready !== '0 || bus.rsp_valid !== '0 || bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL %s_hs s_tready=%b rsp_valid=%b m_tvalid=%b m_tlast=%b required all 0",
               tag, bus.s_tready, bus.rsp_valid, bus.m_tvalid, bus.m_tlast);
    end
    checks++;
    if (bus.rsp_data !== '0 || bus.rsp_err !== 1'b0 || bus.adder_clr !== 1'b0) begin
      errors++;
      $display("FAIL %s_regs rsp_data=%0d rsp_err=%b adder_clr=%b required 0,0,0",
               tag, bus.rsp_data, bus.rsp_err, bus.adder_clr);
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b0;
    bus.s_tvalid = '1;
    bus.s_tlast = '0;
    bus.s_tdata = '0;
    bus.rsp_ready = '0;
    bus.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
    bus.s_tvalid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset_released");
  endtask

  task automatic test_single_req();
    int fh;
    int clr0;
    pk[1][0] = 3; pk[1][1] = 4; pk[1][2] = 5;
    clr0 = clr_cnt;
    send_packet(1, 3, 3, 1'b0, fh);
    checks++;
    if (fh != 2) begin
      errors++;
      $display("FAIL first_beat_latency got=%0d required=2", fh);
    end
    checks++;
    if (clr_cnt - clr0 != 1) begin
      errors++;
      $display("FAIL clr_pulses got=%0d required=1", clr_cnt - clr0);
    end
    get_rsp(1, 64'd12, 1'b0, 3);
  endtask

  task automatic test_two_valid();
    int fh;
    do_reset();
    pk[0][0] = 3; pk[0][1] = 4;
    pk[2][0] = 9;
    drive_beat(2, 0, 1);
    send_packet(0, 2, 2, 1'b0, fh);
    get_rsp(0, 64'd7, 1'b0, 0);
    send_packet(2, 1, 1, 1'b0, fh);
    get_rsp(2, 64'd9, 1'b0, 0);
  endtask

  task automatic test_wrap();
    int fh;
    pk[3][0] = 10; pk[3][1] = 20;
    send_packet(3, 2, 2, 1'b0, fh);
    get_rsp(3, 64'd30, 1'b0, 0);
    pk[0][0] = 1; pk[0][1] = 2; pk[0][2] = 3;
    pk[3][0] = 5; pk[3][1] = 6;
    drive_beat(3, 0, 2);
    send_packet(0, 3, 3, 1'b0, fh);
    get_rsp(0, 64'd6, 1'b0, 0);
    send_packet(3, 2, 2, 1'b0, fh);
    get_rsp(3, 64'd11, 1'b0, 1);
  endtask

  task automatic test_backpressure();
    int fh;
    pk[2][0] = 11; pk[2][1] = 22; pk[2][2] = 33; pk[2][3] = 44;
    send_packet(2, 4, 4, 1'b1, fh);
    get_rsp(2, 64'd110, 1'b0, 5);
  endtask

  task automatic test_reset_mid_packet();
    int fh;
    pk[1][0] = 1; pk[1][1] = 2; pk[1][2] = 3; pk[1][3] = 4;
    send_packet(1, 4, 2, 1'b0, fh);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("reset_mid");
    bus.s_tvalid = '0;
    bus.s_tlast = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    // rr_ptr back at 0 puts req1 ahead of req3
    pk[1][0] = 8; pk[1][1] = 8;
    pk[3][0] = 2;
    drive_beat(3, 0, 1);
    send_packet(1, 2, 2, 1'b0, fh);
    get_rsp(1, 64'd16, 1'b0, 0);
    send_packet(3, 1, 1, 1'b0, fh);
    get_rsp(3, 64'd2, 1'b0, 0);
  endtask

  task automatic test_wait_rsp();
    int fh;
    int n;
    pk[0][0] = 40; pk[0][1] = 2;
    adder_mute = 1'b1;
    send_packet(0, 2, 2, 1'b0, fh);
    n = 0;
`ifdef ADDER_ARB_TIMEOUT_EN
    while (bus.rsp_valid === '0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL timeout_cycles got=%0d required=8", n);
    end
    adder_mute = 1'b0;
    get_rsp(0, 64'd0, 1'b1, 1);
`else
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== '0 || busy !== 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL wait_forever early_cycles=%0d required=0", n);
    end
    adder_mute = 1'b0;
    get_rsp(0, 64'd42, 1'b0, 1);
`endif
  endtask

  initial begin
    bus.s_tvalid = '0;
    bus.s_tlast = '0;
    bus.s_tdata = '0;
    bus.rsp_ready = '0;
    bus.m_tready = 1'b1;
    test_reset();
    test_single_req();
    test_two_valid();
    test_wrap();
    test_backpressure();
    test_reset_mid_packet();
    test_wait_rsp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t required finish before 500000", $time);
    $fatal(1, "bench watchdog expired");
  end
endmodule
